// File: rtl/elementwise_div_float.sv
// Four-lane IEEE-754 divider sharing one radix-2 restoring mantissa divider.
// Optional macro ELEMENTWISE_DIV_RNE_EN selects round-to-nearest-even over truncation.
module elementwise_div_float #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DATA_WIDTH-1:0] a,
    input  logic [4*DATA_WIDTH-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] result
);

    localparam int EXP_W = (DATA_WIDTH == 16) ? 5 : 8;
    localparam int MAN_W = (DATA_WIDTH == 16) ? 10 : 23;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int Q     = MAN_W + 3;
    localparam int XW    = EXP_W + 2;
    localparam int CW    = $clog2(Q);

    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef ELEMENTWISE_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    if (DATA_WIDTH != 32 && DATA_WIDTH != 16) begin : g_bad_width
        $error("elementwise_div_float: DATA_WIDTH must be 16 or 32");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        PACK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

    state_t                         state;
    logic [3:0][DATA_WIDTH-1:0]     a_q;
    logic [3:0][DATA_WIDTH-1:0]     b_q;
    logic [3:0][DATA_WIDTH-1:0]     res_q;
    logic [1:0]                     lane;
    logic [CW-1:0]                  cnt;
    logic                           sign;
    logic signed [XW-1:0]           exp_q;
    special_t                       special;
    logic [MAN_W+1:0]               divisor;
    logic [MAN_W+1:0]               rem;
    logic [Q-1:0]                   quo;

    assign result = res_q;

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  sa;
    logic                  sb;
    logic [EXP_W-1:0]      ea;
    logic [EXP_W-1:0]      eb;
    logic [MAN_W-1:0]      fa;
    logic [MAN_W-1:0]      fb;

    assign op_a = a_q[lane];
    assign op_b = b_q[lane];
    assign {sa, ea, fa} = op_a;
    assign {sb, eb, fb} = op_b;

    // Denormals (exp field 0) are classed as zero regardless of fraction.
    logic a_nan, a_inf, a_zero;
    logic b_nan, b_inf, b_zero;

    assign a_nan  = (&ea) & (|fa);
    assign a_inf  = (&ea) & ~(|fa);
    assign a_zero = ~(|ea);
    assign b_nan  = (&eb) & (|fb);
    assign b_inf  = (&eb) & ~(|fb);
    assign b_zero = ~(|eb);

    special_t sp_class;

    always_comb begin
        sp_class = SP_NONE;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_class = SP_NAN;
        end else if (a_inf | b_zero) begin
            sp_class = SP_INF;
        end else if (a_zero | b_inf) begin
            sp_class = SP_ZERO;
        end
    end

    logic signed [XW-1:0] exp_diff;

    assign exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb})
                    + $signed(XW'(BIAS));

    // rem < 2*divisor holds throughout, so the shifted-out MSB is always 0.
    logic             rem_ge;
    logic [MAN_W:0]   rem_sub;

    assign rem_ge  = rem >= divisor;
    assign rem_sub = rem[MAN_W:0] - divisor[MAN_W:0];

    logic                  norm;
    logic [MAN_W-1:0]      mant;
    logic                  guard;
    logic                  sticky;
    logic                  rnd_up;
    logic [MAN_W:0]        mant_r;
    logic signed [XW-1:0]  exp_n;
    logic signed [XW-1:0]  exp_r;
    logic [DATA_WIDTH-1:0] packed_val;

    always_comb begin
        norm = quo[Q-1];
        if (norm) begin
            mant   = quo[Q-2:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
            exp_n  = exp_q;
        end else begin
            mant   = quo[Q-3:1];
            guard  = quo[0];
            sticky = |rem;
            exp_n  = exp_q - XW'(1);
        end
        rnd_up = RNE & guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
        exp_r  = exp_n + $signed({{(XW-1){1'b0}}, mant_r[MAN_W]});

        packed_val = {sign, {(DATA_WIDTH-1){1'b0}}};
        unique case (special)
            SP_NAN:  packed_val = QNAN;
            SP_INF:  packed_val = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: packed_val = {sign, {(DATA_WIDTH-1){1'b0}}};
            SP_NONE: begin
                if (!exp_r[XW-1] && exp_r >= EXP_MAX) begin
                    packed_val = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (exp_r[XW-1] || exp_r == '0) begin
                    packed_val = {sign, {(DATA_WIDTH-1){1'b0}}};
                end else begin
                    packed_val = {sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
                end
            end
            default: packed_val = QNAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            lane      <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            exp_q     <= '0;
            special   <= SP_NONE;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        lane     <= '0;
                        in_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    sign    <= sa ^ sb;
                    exp_q   <= exp_diff;
                    special <= sp_class;
                    rem     <= {1'b0, 1'b1, fa};
                    divisor <= {1'b0, 1'b1, fb};
                    quo     <= '0;
                    cnt     <= CW'(Q - 1);
                    state   <= ITER;
                end
                ITER: begin
                    rem <= rem_ge ? {rem_sub, 1'b0} : {rem[MAN_W:0], 1'b0};
                    quo <= {quo[Q-2:0], rem_ge};
                    if (cnt == '0) begin
                        state <= PACK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                PACK: begin
                    res_q[lane] <= packed_val;
                    if (lane == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lane  <= lane + 2'd1;
                        state <= SETUP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elementwise_div_float.sv
// Scoreboard bench for elementwise_div_float (float32 and float16 instances).
// Expected quotients come from an integer long-division reference model.
module tb_elementwise_div_float;

    localparam int LAT32 = 112;
    localparam int LAT16 = 60;

`ifdef ELEMENTWISE_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;

    logic         in_valid16;
    logic         in_ready16;
    logic [63:0]  a16;
    logic [63:0]  b16;
    logic         out_valid16;
    logic         out_ready16;
    logic [63:0]  result16;

    always #5 clk = ~clk;

    elementwise_div_float #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    elementwise_div_float #(.DATA_WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [127:0] exp_q[$];
    int           acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Float32 reference: exact integer quotient, then normalise/round/range.
    function automatic logic [31:0] ref_div(input logic [31:0] x,
                                            input logic [31:0] y);
        logic   s;
        int     ex, ey, e;
        longint fx, fy, mx, my, num, qq, rr, kept;
        bit     guard, sticky;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = longint'(x[22:0]);
        fy = longint'(y[22:0]);
        if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0) ||
            (ex == 0 && ey == 0) || (ex == 255 && ey == 255))
            return 32'h7FC00000;
        if (ex == 255 || ey == 0)
            return {s, 8'hFF, 23'h0};
        if (ex == 0 || ey == 255)
            return {s, 31'h0};
        mx  = (longint'(1) << 23) | fx;
        my  = (longint'(1) << 23) | fy;
        num = mx << 25;
        qq  = num / my;
        rr  = num % my;
        e   = ex - ey + 127;
        if (qq >= (longint'(1) << 25)) begin
            kept   = qq >> 2;
            guard  = qq[1];
            sticky = qq[0] || (rr != 0);
        end else begin
            e      = e - 1;
            kept   = qq >> 1;
            guard  = qq[0];
            sticky = rr != 0;
        end
        if (RNE && guard && (sticky || kept[0]))
            kept = kept + 1;
        if (kept == (longint'(1) << 24)) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        if (e >= 255)
            return {s, 8'hFF, 23'h0};
        if (e <= 0)
            return {s, 31'h0};
        return {s, 8'(e), 23'(kept)};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h7F800000;
            3:       return 32'hFF800000;
            4:       return 32'h7FC12345;
            5:       return {1'b0, 8'h00, r[22:0]};
            6:       return r;
            7:       return {r[31], 8'($urandom_range(1, 8)), r[22:0]};
            8:       return {r[31], 8'($urandom_range(245, 254)), r[22:0]};
            default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
        endcase
    endfunction

    logic         prev_ov;
    logic [127:0] mon_ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready)
                acc_q.push_back(cyc + 1);
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out_valid got=1 want=0");
                end else begin
                    chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT32));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result got=%0h want=none", result);
                end else begin
                    mon_ev = exp_q.pop_front();
                    for (int l = 0; l < 4; l++)
                        chk($sformatf("lane%0d", l), 128'(result[l*32 +: 32]),
                            128'(mon_ev[l*32 +: 32]));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [127:0] av, input logic [127:0] bv,
                        input logic [127:0] ev);
        int n;
        exp_q.push_back(ev);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=0 want=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic rand_vec(output logic [127:0] av, output logic [127:0] bv,
                            output logic [127:0] ev);
        logic [31:0] x, y;
        for (int l = 0; l < 4; l++) begin
            x = rnd_op();
            y = rnd_op();
            av[l*32 +: 32] = x;
            bv[l*32 +: 32] = y;
            ev[l*32 +: 32] = ref_div(x, y);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] va, vb, ve;
        logic [127:0] wa, wb, we;
        int n;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        a16         = '0;
        b16         = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_result", result, 128'(0));
        chk("rst16_in_ready", 128'(in_ready16), 128'(1));
        chk("rst16_out_valid", 128'(out_valid16), 128'(0));
        chk("rst16_result", 128'(result16), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        va = {32'h40F00000, 32'h3F800000, 32'h3F800000, 32'h40C00000};
        vb = {32'h3F000000, 32'h40400000, 32'hC0800000, 32'h40000000};
        ve = {32'h41700000, (RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA),
              32'hBE800000, 32'h40400000};
        send(va, vb, ve);
        drain();

        va = {32'h7FC00001, 32'hFF800000, 32'h00000000, 32'h3F800000};
        vb = {32'h3F800000, 32'h40000000, 32'h00000000, 32'h00000000};
        ve = {32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7F800000};
        send(va, vb, ve);

        va = {32'h80000000, 32'h00000001, 32'h00800000, 32'h7F000000};
        vb = {32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3E800000};
        ve = {32'h80000000, 32'h00000000, 32'h00000000, 32'h7F800000};
        send(va, vb, ve);
        drain();

        for (int v = 0; v < 10; v++) begin
            rand_vec(va, vb, ve);
            send(va, vb, ve);
        end
        drain();

        // Backpressure: stall the output while new operands wait at the input.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rand_vec(va, vb, ve);
        send(va, vb, ve);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        rand_vec(wa, wb, we);
        @(posedge clk);
        #1;
        a        = wa;
        b        = wb;
        in_valid = 1'b1;
        exp_q.push_back(we);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_result", result, ve);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_retire_valid", 128'(out_valid), 128'(0));
        chk("bp_retire_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset partway through an operation.
        rand_vec(va, vb, ve);
        send(va, vb, ve);
        repeat (49) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_result", result, 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rand_vec(va, vb, ve);
        send(va, vb, ve);
        drain();

        // Half-precision instance: 1/3 in every lane.
        @(posedge clk);
        #1;
        a16        = {4{16'h3C00}};
        b16        = {4{16'h4200}};
        in_valid16 = 1'b1;
        @(negedge clk);
        chk("h_in_ready", 128'(in_ready16), 128'(1));
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (out_valid16)
                break;
        end
        chk("h_latency", 128'(n), 128'(LAT16));
        chk("h_result", 128'(result16), 128'({4{16'h3555}}));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elementwise_div_float.md
Name: elementwise_div_float

Overview:
- Sequential 4-lane elementwise IEEE-754 divider, result[i] = a[i] / b[i]; the division counterpart of the team's elementwise float multiplier.
- Uses one shared radix-2 restoring mantissa divider, time-multiplexed over lanes 0..3 in order.
- Sits in the vector datapath behind valid/ready handshakes.
- Synthesizable: no real-typed arithmetic.

Parameters:
- DATA_WIDTH, 32: element width. 32 gives float32 (EXP_W=8, MAN_W=23, bias 127). 16 gives float16 (EXP_W=5, MAN_W=10, bias 15). Any other value is an elaboration error.
- Q (derived): MAN_W+3, the number of quotient iterations per lane.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset
- in_valid  input  1  operand vectors valid
- in_ready  output  1  block can accept operands
- a  input  4*DATA_WIDTH  dividend vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- b  input  4*DATA_WIDTH  divisor vector, same packing
- out_valid  output  1  result vector valid
- out_ready  input  1  downstream accepts result
- result  output  4*DATA_WIDTH  quotient vector, same packing

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, result=0, all internal registers cleared. Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, SETUP, ITER, PACK, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: capture a and b, set lane=0, go to SETUP.
- SETUP (1 cycle):
  - Unpack lane: sign = sa^sb, exp diff = ea-eb+bias.
  - Mantissas get the hidden 1.
  - Classify the lane special (see below).
  - Go to ITER.
- ITER (exactly Q cycles):
  - One restoring quotient bit per cycle.
  - Divisor and remainder widths are MAN_W+2.
  - Iterations run even for special lanes, giving fixed latency.
- PACK (1 cycle):
  - If the quotient MSB is 0, shift left 1 and decrement the exponent.
  - Round (see Optional Feature).
  - Write result[lane].
  - If lane==3 go to DONE, else lane+1 and return to SETUP.
- DONE:
  - out_valid=1; result holds stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle retire+accept.
- in_ready=0 in every non-IDLE state; in_valid is ignored there.
- Latency: out_valid asserts 4*(Q+2) cycles after the accept edge (112 for float32, 60 for float16).
- Denormal inputs (exp field 0) are treated as signed zero. Results with biased exponent <=0 flush to signed zero.
- Biased exponent >= 2^EXP_W-1 after rounding gives signed infinity.
- Special lanes, in priority order:
  - Either operand NaN, 0/0, or inf/inf: canonical NaN (0x7FC00000 for float32, 0x7E00 for float16, sign 0).
  - inf/x or x/0 (x nonzero): signed infinity.
  - 0/x or x/inf: signed zero.
- The sign of inf and zero results is always sa^sb.

Optional Feature:
- Macro ELEMENTWISE_DIV_RNE_EN.
- Defined: round-to-nearest-even. Guard bit plus sticky (OR of the remaining quotient bit and the nonzero remainder). A mantissa carry-out increments the exponent, and that increment can overflow to infinity.
- Undefined: truncation (round toward zero). Guard and sticky bits are discarded.
- Latency is identical in both builds.

Test Plan:
- Normal lanes (float32): a={0x40F00000,0x3F800000,0x3F800000,0x40C00000} (lane3..0), b={0x3F000000,0x40400000,0xC0800000,0x40000000}.
  - Expected result lane0..3: 0x40400000, 0xBE800000, then lane2 0x3EAAAAAA (truncate) or 0x3EAAAAAB (RNE), then 0x41700000.
  - out_valid exactly 112 cycles after accept.
- Specials:
  - 0x3F800000/0x00000000 -> 0x7F800000.
  - 0x00000000/0x00000000 -> 0x7FC00000.
  - 0xFF800000/0x40000000 -> 0xFF800000.
  - 0x7FC00001/0x3F800000 -> 0x7FC00000.
- Range limits:
  - 0x7F000000/0x3E800000 -> 0x7F800000.
  - 0x00800000/0x40000000 -> 0x00000000.
  - 0x00000001/0x3F800000 -> 0x00000000.
  - 0x80000000/0x3F800000 -> 0x80000000.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid, with in_valid=1 and new operands driven throughout.
  - Required: result stable, in_ready=0, nothing captured.
  - Raise out_ready: out_valid drops, in_ready=1 the next cycle, the new operands are accepted then.
- Reset mid-operation:
  - Drop rst_n at cycle 50 after accept.
  - Required: out_valid=0, result=0, in_ready=1 immediately.
  - After release, the next operation returns correct results at 112 cycles.
- DATA_WIDTH=16, all lanes 0x3C00/0x4200 -> 0x3555 in both rounding modes; out_valid at 60 cycles.
